// File: rtl/encode.sv
// 6502-style instruction encoder: turns a {group, aaa, addressing mode, operand}
// request into a 1-3 byte stream, tagging each byte with its location counter value.
module encode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_grp,
  input  logic [2:0]  in_aaa,
  input  logic [3:0]  in_mode,
  input  logic [15:0] in_operand,
  input  logic        in_raw,
  input  logic [7:0]  in_opcode,
  input  logic        org_valid,
  input  logic [15:0] org_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic [15:0] out_addr,
  output logic        err
);

  localparam logic [3:0] M_IMP  = 4'd0,  M_ACC  = 4'd1,  M_IMM = 4'd2,  M_ZPG = 4'd3;
  localparam logic [3:0] M_ZPX  = 4'd4,  M_ZPY  = 4'd5,  M_ABS = 4'd6,  M_ABX = 4'd7;
  localparam logic [3:0] M_ABY  = 4'd8,  M_XIND = 4'd9,  M_INDY = 4'd10, M_IND = 4'd11;
  localparam logic [3:0] M_REL  = 4'd12;

  typedef enum logic [1:0] {IDLE, OP, LO, HI} state_t;

  state_t      state, state_nxt;
  logic [1:0]  len_p0;
  logic [7:0]  opcode_p0;
  logic [15:0] operand_p0;
  logic [15:0] addr;
  logic [1:0]  len_req;
  logic [3:0]  dec;
  logic        legal_req;
  logic [7:0]  op_req;
  logic        accept;
  logic        xfer;

  // Instruction length from addressing mode; 0 marks an illegal mode code.
  function automatic logic [1:0] mode_len(input logic [3:0] mode);
    case (mode)
      M_IMP, M_ACC:                                    return 2'd1;
      M_IMM, M_ZPG, M_ZPX, M_ZPY, M_XIND, M_INDY, M_REL: return 2'd2;
      M_ABS, M_ABX, M_ABY, M_IND:                      return 2'd3;
      default:                                         return 2'd0;
    endcase
  endfunction

  // Returns {legal, bbb} for a non-raw request.
  function automatic logic [3:0] decode_std(input logic [1:0] grp, input logic [2:0] aaa,
                                            input logic [3:0] mode);
    logic       ok;
    logic [2:0] bbb;
    ok  = 1'b0;
    bbb = 3'b000;
    case (grp)
      2'b01: case (mode)
        M_XIND: begin ok = 1'b1;             bbb = 3'b000; end
        M_ZPG:  begin ok = 1'b1;             bbb = 3'b001; end
        M_IMM:  begin ok = (aaa != 3'b100);  bbb = 3'b010; end
        M_ABS:  begin ok = 1'b1;             bbb = 3'b011; end
        M_INDY: begin ok = 1'b1;             bbb = 3'b100; end
        M_ZPX:  begin ok = 1'b1;             bbb = 3'b101; end
        M_ABY:  begin ok = 1'b1;             bbb = 3'b110; end
        M_ABX:  begin ok = 1'b1;             bbb = 3'b111; end
        default: ;
      endcase
      2'b10: case (mode)
        M_IMM:  begin ok = (aaa == 3'b101);                     bbb = 3'b000; end
        M_ZPG:  begin ok = 1'b1;                                bbb = 3'b001; end
        M_ACC:  begin ok = !aaa[2];                             bbb = 3'b010; end
        M_ABS:  begin ok = 1'b1;                                bbb = 3'b011; end
        M_ZPX:  begin ok = (aaa != 3'b100) && (aaa != 3'b101);  bbb = 3'b101; end
        M_ZPY:  begin ok = (aaa == 3'b100) || (aaa == 3'b101);  bbb = 3'b101; end
        M_ABX:  begin ok = (aaa != 3'b100) && (aaa != 3'b101);  bbb = 3'b111; end
        M_ABY:  begin ok = (aaa == 3'b101);                     bbb = 3'b111; end
        default: ;
      endcase
      2'b00: case (mode)
        M_IMM:  begin ok = (aaa >= 3'b101);                                  bbb = 3'b000; end
        M_ZPG:  begin ok = (aaa == 3'b001) || aaa[2];                        bbb = 3'b001; end
        M_ABS:  begin ok = (aaa == 3'b001) || (aaa == 3'b010) || aaa[2];     bbb = 3'b011; end
        M_IND:  begin ok = (aaa == 3'b011);                                  bbb = 3'b011; end
        M_ZPX:  begin ok = (aaa == 3'b100) || (aaa == 3'b101);               bbb = 3'b101; end
        M_ABX:  begin ok = (aaa == 3'b101);                                  bbb = 3'b111; end
        M_REL:  begin ok = 1'b1;                                             bbb = 3'b100; end
        default: ;
      endcase
      default: ;
    endcase
    return {ok, bbb};
  endfunction

  always_comb begin
    len_req   = mode_len(in_mode);
    dec       = decode_std(in_grp, in_aaa, in_mode);
    legal_req = 1'b0;
    op_req    = in_opcode;
    if (in_raw) begin
      legal_req = (len_req != 2'd0);
    end else begin
      legal_req = dec[3] && (len_req != 2'd0);
      op_req    = {in_aaa, dec[2:0], in_grp};
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_addr  = addr;
  assign out_last  = ((state == OP) && (len_p0 == 2'd1)) ||
                     ((state == LO) && (len_p0 == 2'd2)) ||
                     (state == HI);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && legal_req) state_nxt = OP;
      OP:   if (xfer) state_nxt = (len_p0 == 2'd1) ? IDLE : LO;
      LO:   if (xfer) state_nxt = (len_p0 == 2'd3) ? HI : IDLE;
      HI:   if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_byte = 8'h00;
    case (state)
      OP:      out_byte = opcode_p0;
      LO:      out_byte = operand_p0[7:0];
      HI:      out_byte = operand_p0[15:8];
      default: out_byte = 8'h00;
    endcase
  end

  // Control state: org load takes priority only in IDLE, where no byte can transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      err    <= 1'b0;
      addr   <= RESET_PC;
      len_p0 <= 2'd0;
    end else begin
      state <= state_nxt;
      err   <= accept && !legal_req;
      if (accept && legal_req) len_p0 <= len_req;
      if ((state == IDLE) && org_valid) addr <= org_addr;
      else if (xfer)                    addr <= addr + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept && legal_req) begin
      opcode_p0  <= op_req;
      operand_p0 <= in_operand;
    end
  end

endmodule

// File: tb/tb_encode.sv
// Self-checking bench for encode: fixed vector table, randomized requests against a
// table-driven opcode model, plus stall and mid-stream reset sequences.
module tb_encode;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_grp;
  logic [2:0]  in_aaa;
  logic [3:0]  in_mode;
  logic [15:0] in_operand;
  logic        in_raw;
  logic [7:0]  in_opcode;
  logic        org_valid;
  logic [15:0] org_addr;
  logic        out_valid, out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [15:0] out_addr;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] pc;

  encode dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_grp(in_grp), .in_aaa(in_aaa), .in_mode(in_mode), .in_operand(in_operand),
    .in_raw(in_raw), .in_opcode(in_opcode),
    .org_valid(org_valid), .org_addr(org_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  grp;
    logic [2:0]  aaa;
    logic [3:0]  mode;
    logic [15:0] operand;
    logic        raw;
    logic [7:0]  opcode;
    logic        use_org;
    logic [15:0] org;
    int          stall_k;
    logic        legal;
    int          len;
    logic [7:0]  b0, b1, b2;
    logic [15:0] addr0;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: instruction length by mode, then an allowed-aaa bitmask per (group, mode).
  function automatic void ref_model(input logic [1:0] grp, input logic [2:0] aaa,
                                    input logic [3:0] mode, input logic raw,
                                    input logic [7:0] opc, output logic legal,
                                    output int len, output logic [7:0] op);
    logic [2:0] bbb;
    logic [7:0] mask;
    case (mode)
      0, 1:                  len = 1;
      2, 3, 4, 5, 9, 10, 12: len = 2;
      6, 7, 8, 11:           len = 3;
      default:               len = 0;
    endcase
    bbb  = 3'b000;
    mask = 8'h00;
    case ({grp, mode})
      {2'b01, 4'd9}:  begin bbb = 0; mask = 8'hFF; end
      {2'b01, 4'd3}:  begin bbb = 1; mask = 8'hFF; end
      {2'b01, 4'd2}:  begin bbb = 2; mask = 8'hEF; end
      {2'b01, 4'd6}:  begin bbb = 3; mask = 8'hFF; end
      {2'b01, 4'd10}: begin bbb = 4; mask = 8'hFF; end
      {2'b01, 4'd4}:  begin bbb = 5; mask = 8'hFF; end
      {2'b01, 4'd8}:  begin bbb = 6; mask = 8'hFF; end
      {2'b01, 4'd7}:  begin bbb = 7; mask = 8'hFF; end
      {2'b10, 4'd2}:  begin bbb = 0; mask = 8'h20; end
      {2'b10, 4'd3}:  begin bbb = 1; mask = 8'hFF; end
      {2'b10, 4'd1}:  begin bbb = 2; mask = 8'h0F; end
      {2'b10, 4'd6}:  begin bbb = 3; mask = 8'hFF; end
      {2'b10, 4'd4}:  begin bbb = 5; mask = 8'hCF; end
      {2'b10, 4'd5}:  begin bbb = 5; mask = 8'h30; end
      {2'b10, 4'd7}:  begin bbb = 7; mask = 8'hCF; end
      {2'b10, 4'd8}:  begin bbb = 7; mask = 8'h20; end
      {2'b00, 4'd2}:  begin bbb = 0; mask = 8'hE0; end
      {2'b00, 4'd3}:  begin bbb = 1; mask = 8'hF2; end
      {2'b00, 4'd6}:  begin bbb = 3; mask = 8'hF6; end
      {2'b00, 4'd11}: begin bbb = 3; mask = 8'h08; end
      {2'b00, 4'd4}:  begin bbb = 5; mask = 8'h30; end
      {2'b00, 4'd7}:  begin bbb = 7; mask = 8'h20; end
      {2'b00, 4'd12}: begin bbb = 4; mask = 8'hFF; end
      default: ;
    endcase
    if (raw) begin
      legal = (len != 0);
      op    = opc;
    end else begin
      legal = mask[aaa] && (len != 0);
      op    = {aaa, bbb, grp};
    end
  endfunction

  task automatic run_instr(input logic [1:0] grp, input logic [2:0] aaa, input logic [3:0] mode,
                           input logic [15:0] operand, input logic raw, input logic [7:0] opc,
                           input logic use_org, input logic [15:0] org,
                           input int stall_k, input int stall_n,
                           input logic legal, input int len,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [15:0] a0);
    logic [7:0]  exp_b[3];
    logic [15:0] ea;
    int          waited;
    logic        dead;
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    dead = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_grp = grp; in_aaa = aaa; in_mode = mode;
    in_operand = operand; in_raw = raw; in_opcode = opc;
    org_valid = use_org; org_addr = org;
    @(negedge clk);
    in_valid = 1'b0; org_valid = 1'b0;
    if (!legal) begin
      chk("err_pulse", err, 1);
      chk("err_no_valid", out_valid, 0);
      chk("err_addr", out_addr, a0);
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("err_idle", out_valid, 0);
    end else begin
      chk("no_err", err, 0);
      for (int k = 0; k < len; k++) begin
        if (!dead) begin
          waited = 0;
          while (!out_valid && waited < 4) begin
            @(negedge clk);
            waited++;
          end
          if (!out_valid) begin
            chk("byte_timeout", 0, 1);
            dead = 1'b1;
          end else begin
            ea = a0 + 16'(k);
            chk("byte", out_byte, exp_b[k]);
            chk("last", out_last, (k == len - 1));
            chk("addr", out_addr, ea);
            chk("busy", in_ready, 0);
            if (k == stall_k) begin
              out_ready = 1'b0;
              org_valid = 1'b1;
              org_addr  = 16'($urandom);
              repeat (stall_n) begin
                @(negedge clk);
                chk("stall_valid", out_valid, 1);
                chk("stall_byte", out_byte, exp_b[k]);
                chk("stall_last", out_last, (k == len - 1));
                chk("stall_addr", out_addr, ea);
              end
              org_valid = 1'b0;
              out_ready = 1'b1;
            end
            @(negedge clk);
          end
        end
      end
      if (!dead) chk("idle_after", out_valid, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_legal;
    int          r_len;
    logic [7:0]  r_op;
    logic [1:0]  g;
    logic [2:0]  a;
    logic [3:0]  m;
    logic [15:0] opd, org;
    logic        raw, uo;
    logic [7:0]  opc;

    tbl[0]  = '{2'b01, 3'b101, 4'd6,  16'h1234, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b1, 3, 8'hAD, 8'h34, 8'h12, 16'h0000};
    tbl[1]  = '{2'b10, 3'b000, 4'd1,  16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b1, 1, 8'h0A, 8'h00, 8'h00, 16'h0003};
    tbl[2]  = '{2'b10, 3'b101, 4'd5,  16'h0080, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b1, 2, 8'hB6, 8'h80, 8'h00, 16'h0004};
    tbl[3]  = '{2'b00, 3'b011, 4'd11, 16'h3000, 1'b0, 8'h00, 1'b0, 16'h0000,  1, 1'b1, 3, 8'h6C, 8'h00, 8'h30, 16'h0006};
    tbl[4]  = '{2'b01, 3'b100, 4'd2,  16'h5555, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b0, 0, 8'h00, 8'h00, 8'h00, 16'h0009};
    tbl[5]  = '{2'b11, 3'b000, 4'd6,  16'hC000, 1'b1, 8'h20, 1'b1, 16'hFFFF, -1, 1'b1, 3, 8'h20, 8'h00, 8'hC0, 16'hFFFF};
    tbl[6]  = '{2'b11, 3'b000, 4'd3,  16'h0010, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b0, 0, 8'h00, 8'h00, 8'h00, 16'h0002};
    tbl[7]  = '{2'b00, 3'b000, 4'd13, 16'h0000, 1'b1, 8'hEA, 1'b0, 16'h0000, -1, 1'b0, 0, 8'h00, 8'h00, 8'h00, 16'h0002};
    tbl[8]  = '{2'b00, 3'b110, 4'd12, 16'h00FE, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b1, 2, 8'hD0, 8'hFE, 8'h00, 16'h0002};
    tbl[9]  = '{2'b10, 3'b101, 4'd2,  16'h0042, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b1, 2, 8'hA2, 8'h42, 8'h00, 16'h0004};
    tbl[10] = '{2'b10, 3'b100, 4'd5,  16'h0010, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b1, 2, 8'h96, 8'h10, 8'h00, 16'h0006};
    tbl[11] = '{2'b10, 3'b100, 4'd1,  16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b0, 0, 8'h00, 8'h00, 8'h00, 16'h0008};
    tbl[12] = '{2'b01, 3'b101, 4'd10, 16'h0011, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b1, 2, 8'hB1, 8'h11, 8'h00, 16'h0008};
    tbl[13] = '{2'b00, 3'b001, 4'd3,  16'h0050, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b1, 2, 8'h24, 8'h50, 8'h00, 16'h000A};
    tbl[14] = '{2'b00, 3'b000, 4'd3,  16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 1'b0, 0, 8'h00, 8'h00, 8'h00, 16'h000C};
    tbl[15] = '{2'b11, 3'b111, 4'd0,  16'h0000, 1'b1, 8'hEA, 1'b0, 16'h0000, -1, 1'b1, 1, 8'hEA, 8'h00, 8'h00, 16'h000C};

    i_rst_n = 1'b0; in_valid = 1'b0; in_grp = 2'b00; in_aaa = 3'b000; in_mode = 4'd0;
    in_operand = 16'h0000; in_raw = 1'b0; in_opcode = 8'h00;
    org_valid = 1'b0; org_addr = 16'h0000; out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_byte", out_byte, 8'h00);
    chk("rst_addr", out_addr, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    chk("rst_ready", in_ready, 1);

    for (int i = 0; i < 16; i++) begin
      run_instr(tbl[i].grp, tbl[i].aaa, tbl[i].mode, tbl[i].operand, tbl[i].raw, tbl[i].opcode,
                tbl[i].use_org, tbl[i].org, tbl[i].stall_k, 5, tbl[i].legal, tbl[i].len,
                tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].addr0);
    end
    pc = 16'h000D;

    for (int i = 0; i < 300; i++) begin
      g   = 2'($urandom);
      a   = 3'($urandom);
      m   = 4'($urandom);
      opd = 16'($urandom);
      raw = ($urandom_range(0, 3) == 0);
      opc = 8'($urandom);
      uo  = ($urandom_range(0, 7) == 0);
      org = (($urandom_range(0, 1) == 0) ? 16'hFFFE : 16'($urandom));
      ref_model(g, a, m, raw, opc, r_legal, r_len, r_op);
      if (uo) pc = org;
      run_instr(g, a, m, opd, raw, opc, uo, org, $urandom_range(0, 3), $urandom_range(0, 3),
                r_legal, r_len, r_op, opd[7:0], opd[15:8], pc);
      if (r_legal) pc = pc + 16'(r_len);
    end

    // Reset while the LO byte of a 3-byte instruction is on the output.
    @(negedge clk);
    in_valid = 1'b1; in_grp = 2'b01; in_aaa = 3'b101; in_mode = 4'd6;
    in_operand = 16'h5678; in_raw = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_op", out_byte, 8'hAD);
    @(negedge clk);
    chk("mid_lo", out_byte, 8'h78);
    chk("mid_lo_valid", out_valid, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_addr", out_addr, 16'h0000);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_byte", out_byte, 8'h00);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", out_valid, 0);
    end
    run_instr(2'b10, 3'b000, 4'd1, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, -1, 0,
              1'b1, 1, 8'h0A, 8'h00, 8'h00, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encode.md
ENCODE -- requirements
Module: encode

Interface
REQ-001 SHALL provide parameter RESET_PC, default 16'h0000, meaning initial value of the location counter out_addr.
REQ-002 SHALL provide port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL provide port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide ports in_valid input 1, in_ready output 1; instruction request handshake, transfer when both high on a clock edge.
REQ-005 SHALL provide ports in_grp input 2 (opcode bits 1:0), in_aaa input 3 (opcode bits 7:5), in_mode input 4 (addressing mode), in_operand input 16, in_raw input 1, in_opcode input 8.
REQ-006 SHALL provide ports org_valid input 1, org_addr input 16; location counter load.
REQ-007 SHALL provide ports out_valid output 1, out_ready input 1, out_byte output 8, out_last output 1, out_addr output 16; byte stream and byte location.
REQ-008 SHALL provide port err output 1; one-cycle pulse on a rejected request.

Function
REQ-009 Mode codes SHALL be: 0 IMP, 1 ACC, 2 IMM, 3 ZPG, 4 ZPX, 5 ZPY, 6 ABS, 7 ABX, 8 ABY, 9 XIND, 10 INDY, 11 IND, 12 REL; 13-15 illegal.
REQ-010 Length SHALL be 1 for IMP/ACC; 2 for IMM, ZPG, ZPX, ZPY, XIND, INDY, REL; 3 for ABS, ABX, ABY, IND.
REQ-011 Non-raw opcode SHALL be {in_aaa, bbb, in_grp}, bbb derived from grp/mode.
REQ-012 grp 01: XIND 000, ZPG 001, IMM 010, ABS 011, INDY 100, ZPX 101, ABY 110, ABX 111; IMM with aaa 100 illegal; other modes illegal.
REQ-013 grp 10: IMM 000 only aaa 101; ZPG 001; ACC 010 only aaa 000-011; ABS 011; ZPX 101 only aaa not 100/101; ZPY 101 only aaa 100/101; ABX 111 only aaa not 100/101; ABY 111 only aaa 101; other modes illegal.
REQ-014 grp 00: IMM 000 only aaa 101-111; ZPG 001 only aaa 001,100-111; ABS 011 only aaa 001,010,100-111; IND 011 only aaa 011; ZPX 101 only aaa 100/101; ABX 111 only aaa 101; REL 100 any aaa; other modes illegal.
REQ-015 grp 11 SHALL be illegal when in_raw=0.
REQ-016 in_raw=1 SHALL emit in_opcode unchanged, length per in_mode, no legality check except mode 13-15 illegal.
REQ-017 FSM SHALL have states IDLE, OP, LO, HI; in_ready=1 only in IDLE.
REQ-018 IDLE accept of legal request SHALL capture opcode, operand, length and go to OP next cycle.
REQ-019 IDLE accept of illegal request SHALL assert err for exactly the next cycle, stay IDLE, emit nothing, leave out_addr unchanged.
REQ-020 In OP/LO/HI out_valid=1; out_byte = opcode, operand[7:0], operand[15:8] respectively.
REQ-021 A byte SHALL advance only on out_valid&&out_ready: OP->LO (len>=2) or IDLE; LO->HI (len 3) or IDLE; HI->IDLE.
REQ-022 While out_ready=0, out_byte, out_last, out_addr SHALL hold stable.
REQ-023 out_last SHALL be 1 exactly on the final byte of an instruction.
REQ-024 out_addr SHALL equal location of current byte and increment by 1 (mod 2^16, FFFF->0000) per transferred byte.
REQ-025 org_valid SHALL load out_addr<=org_addr only in IDLE; if in_valid also high that cycle, load first and request accepted the same edge, first byte located at org_addr; org_valid outside IDLE ignored.
REQ-026 Minimum SHALL be one IDLE cycle between instructions (no back-to-back accept).

Reset
REQ-027 i_rst_n low SHALL immediately force IDLE, out_valid=0, out_last=0, err=0, out_byte=8'h00, out_addr=RESET_PC, in_ready=1 after deassert; reset mid-stream discards remaining bytes.

Verification
REQ-028 LDA abs: grp 01, aaa 101, mode 6, operand 1234 -> bytes AD,34,12; out_last on 12; out_addr 0000,0001,0002.
REQ-029 ASL A: grp 10, aaa 000, mode 1 -> single byte 0A with out_last=1; LDX zpg,Y operand 0080 -> B6,80; JMP ind operand 3000 -> 6C,00,30.
REQ-030 STA imm (grp 01, aaa 101->100, mode 2) -> err one cycle, out_valid stays 0, out_addr unchanged.
REQ-031 org_valid with org_addr FFFF plus raw 20 mode 6 operand C000 -> 20,00,C0 at FFFF,0000,0001.
REQ-032 out_ready held low 5 cycles on LO byte -> byte/addr/last stable; resume completes normally.
REQ-033 i_rst_n low during LO byte -> out_valid drops immediately, out_addr=RESET_PC, no HI byte after release.
